wishbone_master_arbiter: RTL and testbench
==========================================

Name: wishbone_master_arbiter

Overview:
Two-master to one-port Wishbone arbiter. It shares the interconnect's master port between the host-side wishbone_master (m0) and a second bus master (m1), for example a DMA engine or test sequencer. Grant is held for a whole cycle (cyc high), using round-robin or fixed priority. A watchdog aborts any strobe the slave never acknowledges, so a bad address cannot hang the host interface.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin; 1 = fixed priority with m0 highest
TIMEOUT_CYCLES, 1024, stb-without-ack cycles before abort; 0 disables the watchdog
TIMEOUT_WIDTH, 16, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_WIDTH

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i_mN_we / i_mN_cyc / i_mN_stb  in  1 each  master N (N=0,1) bus control
i_mN_sel  in  4  master N byte select
i_mN_adr  in  32  master N address
i_mN_dat  in  32  master N write data
o_mN_dat  out  32  read data to master N
o_mN_ack  out  1  ack to master N
o_mN_int  out  1  interrupt to master N (copy of i_s_int)
o_s_we / o_s_cyc / o_s_stb  out  1 each  to interconnect
o_s_sel  out  4  to interconnect
o_s_adr  out  32  to interconnect
o_s_dat  out  32  write data to interconnect
i_s_dat  in  32  read data from interconnect
i_s_ack  in  1  ack from interconnect
i_s_int  in  1  interrupt from interconnect
o_grant  out  2  one-hot current owner; 00 = none
o_timeout  out  1  sticky flag, set on any watchdog abort
i_timeout_clr  in  1  synchronous clear of o_timeout

Behaviour:
- Reset (rst=0, async): state IDLE; o_grant=00; last_served=m1, so m0 wins the first tie; watchdog count=0; o_timeout=0. All o_s_* and o_mN_ack/dat are 0 because no master is granted. o_mN_int is a combinational copy of i_s_int and is not reset-gated.
- States:
  - IDLE: no owner.
  - OWN0 / OWN1: master 0 or 1 owns the port.
  - ABORT0 / ABORT1: watchdog abort in progress for that master.
- IDLE, arbitration decision registered:
  - One requester (cyc=1): that master is granted on the next cycle.
  - Both request, PRIORITY_MODE=1: m0 is granted.
  - Both request, PRIORITY_MODE=0: the master other than last_served is granted.
  - Latency is exactly one cycle from cyc rising to o_grant.
- OWNx:
  - o_s_{we,cyc,stb,sel,adr,dat} are combinationally muxed from master x.
  - o_mx_dat = i_s_dat and o_mx_ack = i_s_ack.
  - The non-owner sees ack=0, dat=0. Its request stays pending and is never dropped or acked.
  - When i_mx_cyc=0: go to IDLE, set last_served=x, o_grant=00. There is one dead cycle before the next grant.
  - Fixed priority does not preempt: m0 waits for m1 to release cyc.
- Watchdog, active only when TIMEOUT_CYCLES != 0:
  - In OWNx, count increments each cycle with stb=1 and i_s_ack=0.
  - Count clears on ack, on stb=0, and on any state change.
  - When count == TIMEOUT_CYCLES-1 and ack is still 0: go to ABORTx.
- ABORTx, one cycle:
  - o_s_cyc and o_s_stb forced to 0.
  - o_mx_ack=1 and o_mx_dat=32'h00000000.
  - o_timeout is set.
  - Next state is OWNx, so a burst continues with its next beat.
- A late i_s_ack arriving during ABORTx is ignored.
- o_timeout: sticky. i_timeout_clr clears it, except that a set in the same cycle as the clear wins.
- A master dropping cyc mid-transfer is treated as release. The arbiter is not responsible for slave-side recovery.
- Both masters toggling cyc on the same cycle as a release: IDLE re-arbitrates using the updated last_served.

Decomposition:
- Shared package wb_arb_pkg:
  - state encoding constants: IDLE, OWN0, OWN1, ABORT0, ABORT1
  - PRIORITY_RR=0 and PRIORITY_FIXED=1
  - GRANT_NONE=2'b00
- One natural sub-module, wb_arb_watchdog: the counter, compare and abort pulse, parameterised on TIMEOUT_CYCLES and TIMEOUT_WIDTH.
- The data/control mux stays in the top level.

Test Plan:
1. Reset then m0 single read of adr 0x00000004; slave acks with 0x12345678 after 3 cycles -> o_grant=01 one cycle after cyc, o_m0_dat=0x12345678 with ack, o_grant=00 the cycle after cyc drops.
2. PRIORITY_MODE=0, m0 and m1 raise cyc on the same cycle, each doing 4 accesses, repeated twice -> grants alternate m0, m1, m0, m1. m1 sees ack=0 for the whole m0 ownership.
3. PRIORITY_MODE=1, m1 owns with a 2-beat burst and m0 requests mid-burst -> m1 completes both beats, then m0 is granted. With both requesting from IDLE, m0 wins 3 out of 3 trials.
4. TIMEOUT_CYCLES=8, m0 strobes and the slave never acks -> o_m0_ack=1 with dat=0 eight cycles after stb; o_s_stb=0 for that cycle; o_timeout=1 and held; i_timeout_clr pulse -> o_timeout=0.
5. rst asserted low mid-burst while m1 is owner -> o_grant=00 and o_s_cyc=0 immediately (async). After release with both requesting, m0 is granted first.
6. i_s_int=1 during m1 ownership -> o_m0_int=1 and o_m1_int=1 in the same cycle.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants for the two-master Wishbone arbiter: state encoding,
// priority modes and the idle grant value.
package wb_arb_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] OWN0   = 3'd1;
    localparam logic [2:0] OWN1   = 3'd2;
    localparam logic [2:0] ABORT0 = 3'd3;
    localparam logic [2:0] ABORT1 = 3'd4;

    localparam int unsigned PRIORITY_RR    = 0;
    localparam int unsigned PRIORITY_FIXED = 1;

    localparam logic [1:0] GRANT_NONE = 2'b00;

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stalled-strobe watchdog: counts owner cycles with stb high and no ack and
// pulses expire on the last allowed cycle. TIMEOUT_CYCLES=0 disables it.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stb,
    input  logic ack,
    output logic expire
);

    localparam bit                       ENABLED    = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMEOUT_WIDTH-1:0] LAST_COUNT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_WIDTH-1:0] count_q;
    logic                     stalled;

    assign stalled = ENABLED && active && stb && !ack;
    assign expire  = stalled && (count_q == LAST_COUNT);

    // Leaving the owner state drops active, which also clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (stalled && !expire) begin
            count_q <= count_q + TIMEOUT_WIDTH'(1);
        end else begin
            count_q <= '0;
        end
    end

endmodule

// File: rtl/wishbone_master_arbiter.sv
// Two-master to one-port Wishbone arbiter. Grant is held for a whole cyc,
// round-robin or fixed priority, with a watchdog that aborts unacked strobes.
module wishbone_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TIMEOUT_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    input  logic [3:0]  i_m0_sel,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    output logic [31:0] o_m0_dat,
    output logic        o_m0_ack,
    output logic        o_m0_int,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    input  logic [3:0]  i_m1_sel,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    output logic [31:0] o_m1_dat,
    output logic        o_m1_ack,
    output logic        o_m1_int,
    output logic        o_s_we,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    output logic [3:0]  o_s_sel,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    input  logic [31:0] i_s_dat,
    input  logic        i_s_ack,
    input  logic        i_s_int,
    output logic [1:0]  o_grant,
    output logic        o_timeout,
    input  logic        i_timeout_clr
);

    localparam bit FIXED = (PRIORITY_MODE == PRIORITY_FIXED);

    logic [2:0]  state_q, state_d;
    logic        last_m1_q, last_m1_d;
    logic        timeout_q;
    logic        owner_m1, owning, in_own, in_abort;
    logic        cur_cyc, cur_stb;
    logic        expire;
    logic        resp_ack;
    logic [31:0] resp_dat;

    assign owner_m1 = (state_q == OWN1) || (state_q == ABORT1);
    assign in_own   = (state_q == OWN0) || (state_q == OWN1);
    assign in_abort = (state_q == ABORT0) || (state_q == ABORT1);
    assign owning   = in_own || in_abort;
    assign cur_cyc  = owner_m1 ? i_m1_cyc : i_m0_cyc;
    assign cur_stb  = owner_m1 ? i_m1_stb : i_m0_stb;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .active(in_own && cur_cyc),
        .stb   (cur_stb),
        .ack   (i_s_ack),
        .expire(expire)
    );

    // last_m1 tracks which master was served last; reset value makes m0 win the first tie.
    always_comb begin
        state_d   = state_q;
        last_m1_d = last_m1_q;
        case (state_q)
            IDLE: begin
                if (i_m0_cyc && i_m1_cyc) begin
                    state_d = (FIXED || last_m1_q) ? OWN0 : OWN1;
                end else if (i_m0_cyc) begin
                    state_d = OWN0;
                end else if (i_m1_cyc) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                if (!i_m0_cyc) begin
                    state_d   = IDLE;
                    last_m1_d = 1'b0;
                end else if (expire) begin
                    state_d = ABORT0;
                end
            end
            OWN1: begin
                if (!i_m1_cyc) begin
                    state_d   = IDLE;
                    last_m1_d = 1'b1;
                end else if (expire) begin
                    state_d = ABORT1;
                end
            end
            ABORT0:  state_d = OWN0;
            ABORT1:  state_d = OWN1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_m1_q <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_m1_q <= last_m1_d;
            if (expire) begin
                timeout_q <= 1'b1;
            end else if (i_timeout_clr) begin
                timeout_q <= 1'b0;
            end
        end
    end

    assign resp_ack = in_abort ? 1'b1 : i_s_ack;
    assign resp_dat = in_abort ? 32'h0000_0000 : i_s_dat;

    always_comb begin
        o_s_we   = 1'b0;
        o_s_cyc  = 1'b0;
        o_s_stb  = 1'b0;
        o_s_sel  = 4'h0;
        o_s_adr  = 32'h0;
        o_s_dat  = 32'h0;
        o_m0_ack = 1'b0;
        o_m0_dat = 32'h0;
        o_m1_ack = 1'b0;
        o_m1_dat = 32'h0;
        if (owning) begin
            o_s_we  = owner_m1 ? i_m1_we  : i_m0_we;
            o_s_sel = owner_m1 ? i_m1_sel : i_m0_sel;
            o_s_adr = owner_m1 ? i_m1_adr : i_m0_adr;
            o_s_dat = owner_m1 ? i_m1_dat : i_m0_dat;
            o_s_cyc = in_own && cur_cyc;
            o_s_stb = in_own && cur_stb;
            if (owner_m1) begin
                o_m1_ack = resp_ack;
                o_m1_dat = resp_dat;
            end else begin
                o_m0_ack = resp_ack;
                o_m0_dat = resp_dat;
            end
        end
    end

    assign o_grant   = owning ? {owner_m1, !owner_m1} : GRANT_NONE;
    assign o_timeout = timeout_q;
    assign o_m0_int  = i_s_int;
    assign o_m1_int  = i_s_int;

endmodule

// File: tb/tb_wishbone_master_arbiter.sv
// Bench for wishbone_master_arbiter: a round-robin and a fixed-priority instance
// share stimulus; every output is compared each cycle against a transaction-level model.
module tb_wishbone_master_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_we[2], m_cyc[2], m_stb[2];
    logic [3:0]  m_sel[2];
    logic [31:0] m_adr[2], m_dat[2];
    logic [31:0] s_rdat;
    logic        s_ack, s_int, tclr;

    logic [31:0] m0_rd[2], m1_rd[2], s_adr[2], s_wd[2];
    logic        m0_ack[2], m1_ack[2], m0_int[2], m1_int[2];
    logic        s_we[2], s_cyc[2], s_stb[2], tmo[2];
    logic [3:0]  s_sel[2];
    logic [1:0]  grant[2];

    int total = 0;
    int bad   = 0;

    // model: owner (-1 none), abort in progress, stall run length, last served, sticky flag
    int own[2], stall[2], last[2];
    bit abt[2], tf[2];
    int n_own[2], n_stall[2], n_last[2];
    bit n_abt[2], n_tf[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wishbone_master_arbiter #(
            .PRIORITY_MODE (g),
            .TIMEOUT_CYCLES(TO),
            .TIMEOUT_WIDTH (4)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .i_m0_we      (m_we[0]),
            .i_m0_cyc     (m_cyc[0]),
            .i_m0_stb     (m_stb[0]),
            .i_m0_sel     (m_sel[0]),
            .i_m0_adr     (m_adr[0]),
            .i_m0_dat     (m_dat[0]),
            .o_m0_dat     (m0_rd[g]),
            .o_m0_ack     (m0_ack[g]),
            .o_m0_int     (m0_int[g]),
            .i_m1_we      (m_we[1]),
            .i_m1_cyc     (m_cyc[1]),
            .i_m1_stb     (m_stb[1]),
            .i_m1_sel     (m_sel[1]),
            .i_m1_adr     (m_adr[1]),
            .i_m1_dat     (m_dat[1]),
            .o_m1_dat     (m1_rd[g]),
            .o_m1_ack     (m1_ack[g]),
            .o_m1_int     (m1_int[g]),
            .o_s_we       (s_we[g]),
            .o_s_cyc      (s_cyc[g]),
            .o_s_stb      (s_stb[g]),
            .o_s_sel      (s_sel[g]),
            .o_s_adr      (s_adr[g]),
            .o_s_dat      (s_wd[g]),
            .i_s_dat      (s_rdat),
            .i_s_ack      (s_ack),
            .i_s_int      (s_int),
            .o_grant      (grant[g]),
            .o_timeout    (tmo[g]),
            .i_timeout_clr(tclr)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k] = -1; abt[k] = 1'b0; stall[k] = 0; last[k] = 1; tf[k] = 1'b0;
        end
    endtask

    task automatic compare_and_step(input int k);
        logic [31:0] e_rd[2];
        logic        e_ack[2];
        logic        e_we, e_cyc, e_stb, set;
        logic [3:0]  e_sel;
        logic [31:0] e_adr, e_wd;
        logic [1:0]  e_g;
        int          o;
        e_rd[0] = '0; e_rd[1] = '0; e_ack[0] = 1'b0; e_ack[1] = 1'b0;
        e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0; e_sel = '0; e_adr = '0; e_wd = '0; e_g = 2'b00;
        o = own[k];
        if (o >= 0) begin
            e_g   = 2'(1 << o);
            e_we  = m_we[o];
            e_sel = m_sel[o];
            e_adr = m_adr[o];
            e_wd  = m_dat[o];
            if (abt[k]) begin
                e_ack[o] = 1'b1;
                e_rd[o]  = 32'h0;
            end else begin
                e_cyc    = m_cyc[o];
                e_stb    = m_stb[o];
                e_ack[o] = s_ack;
                e_rd[o]  = s_rdat;
            end
        end
        chk($sformatf("grant%0d", k),   32'(grant[k]),  32'(e_g));
        chk($sformatf("s_cyc%0d", k),   32'(s_cyc[k]),  32'(e_cyc));
        chk($sformatf("s_stb%0d", k),   32'(s_stb[k]),  32'(e_stb));
        chk($sformatf("s_we%0d", k),    32'(s_we[k]),   32'(e_we));
        chk($sformatf("s_sel%0d", k),   32'(s_sel[k]),  32'(e_sel));
        chk($sformatf("s_adr%0d", k),   s_adr[k],       e_adr);
        chk($sformatf("s_dat%0d", k),   s_wd[k],        e_wd);
        chk($sformatf("m0_ack%0d", k),  32'(m0_ack[k]), 32'(e_ack[0]));
        chk($sformatf("m0_dat%0d", k),  m0_rd[k],       e_rd[0]);
        chk($sformatf("m1_ack%0d", k),  32'(m1_ack[k]), 32'(e_ack[1]));
        chk($sformatf("m1_dat%0d", k),  m1_rd[k],       e_rd[1]);
        chk($sformatf("m0_int%0d", k),  32'(m0_int[k]), 32'(s_int));
        chk($sformatf("m1_int%0d", k),  32'(m1_int[k]), 32'(s_int));
        chk($sformatf("timeout%0d", k), 32'(tmo[k]),    32'(tf[k]));

        n_own[k] = own[k]; n_abt[k] = abt[k]; n_stall[k] = stall[k]; n_last[k] = last[k];
        n_tf[k] = tf[k];
        set = 1'b0;
        if (!rst) begin
            n_own[k] = -1; n_abt[k] = 1'b0; n_stall[k] = 0; n_last[k] = 1; n_tf[k] = 1'b0;
        end else begin
            if (o < 0) begin
                n_stall[k] = 0;
                if (m_cyc[0] && m_cyc[1]) n_own[k] = (k == 1) ? 0 : 1 - last[k];
                else if (m_cyc[0])        n_own[k] = 0;
                else if (m_cyc[1])        n_own[k] = 1;
            end else if (abt[k]) begin
                n_abt[k]   = 1'b0;
                n_stall[k] = 0;
            end else if (!m_cyc[o]) begin
                n_last[k]  = o;
                n_own[k]   = -1;
                n_stall[k] = 0;
            end else if (m_stb[o] && !s_ack) begin
                if (stall[k] + 1 == TO) begin
                    n_abt[k]   = 1'b1;
                    n_stall[k] = 0;
                    set        = 1'b1;
                end else begin
                    n_stall[k] = stall[k] + 1;
                end
            end else begin
                n_stall[k] = 0;
            end
            if (set)       n_tf[k] = 1'b1;
            else if (tclr) n_tf[k] = 1'b0;
        end
    endtask

    // Check at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        @(negedge clk);
        for (int k = 0; k < 2; k++) compare_and_step(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            own[k] = n_own[k]; abt[k] = n_abt[k]; stall[k] = n_stall[k];
            last[k] = n_last[k]; tf[k] = n_tf[k];
        end
    endtask

    task automatic idle_masters();
        for (int j = 0; j < 2; j++) begin
            m_cyc[j] = 1'b0; m_stb[j] = 1'b0; m_we[j] = 1'b0;
            m_sel[j] = 4'h0; m_adr[j] = 32'h0; m_dat[j] = 32'h0;
        end
        s_ack = 1'b0; s_rdat = 32'h0; s_int = 1'b0; tclr = 1'b0;
    endtask

    initial begin
        int ack_pct, stb_pct;
        idle_masters();
        model_reset();
        cycle();
        cycle();
        rst = 1'b1;
        cycle();

        // single read by m0, ack on the third owned cycle
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_0004; m_sel[0] = 4'hf;
        cycle();
        cycle();
        cycle();
        s_ack = 1'b1; s_rdat = 32'h1234_5678;
        cycle();
        s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        cycle();
        cycle();

        // stalled strobe runs into the watchdog, then the flag is cleared
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'hdead_0000;
        repeat (TO + 5) cycle();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        cycle();
        cycle();
        tclr = 1'b1;
        cycle();
        tclr = 1'b0;
        cycle();

        // asynchronous reset while m1 owns mid-burst, with both masters then requesting
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_0100;
        cycle();
        cycle();
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_grant%0d", k), 32'(grant[k]), 32'h0);
            chk($sformatf("rst_s_cyc%0d", k), 32'(s_cyc[k]), 32'h0);
        end
        model_reset();
        cycle();
        rst = 1'b1;
        cycle();
        for (int k = 0; k < 2; k++) chk($sformatf("post_rst_grant%0d", k), 32'(grant[k]), 32'h1);
        cycle();
        idle_masters();
        cycle();
        cycle();

        // randomized traffic, alternating between acking and stalling slave phases
        for (int i = 0; i < 1600; i++) begin
            if ((i / 200) % 2 == 1) begin
                ack_pct = 0; stb_pct = 100;
            end else begin
                ack_pct = 50; stb_pct = 75;
            end
            for (int j = 0; j < 2; j++) begin
                if (!m_cyc[j]) m_cyc[j] = ($urandom % 4 == 0);
                else if ($urandom % 16 == 0) m_cyc[j] = 1'b0;
                m_stb[j] = m_cyc[j] && (($urandom % 100) < ack_pct + stb_pct - ack_pct);
                m_we[j]  = 1'($urandom);
                m_sel[j] = 4'($urandom);
                m_adr[j] = $urandom;
                m_dat[j] = $urandom;
            end
            s_ack  = (($urandom % 100) < ack_pct);
            s_rdat = $urandom;
            s_int  = 1'($urandom);
            tclr   = ($urandom % 16 == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
